// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: two-channel L298-style H-bridge PWM driver with coast dead-time on reversal.
// Optional MOTOR_RAMP_EN: the applied duty code slews by one step per PWM period.
module motor_pwm_driver #(
    parameter int PERIOD_CYC   = 100000,
    parameter int DEAD_PERIODS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] DutyCycleA,
    input  logic [1:0] DutyCycleB,
    input  logic       FWDA,
    input  logic       BWDA,
    input  logic       FWDB,
    input  logic       BWDB,
    output logic       ENA,
    output logic       ENB,
    output logic       IN1A,
    output logic       IN2A,
    output logic       IN1B,
    output logic       IN2B,
    output logic       FaultA,
    output logic       FaultB,
    output logic       PeriodTick,
    output logic [1:0] dbg_state_a_o,
    output logic [1:0] dbg_state_b_o
);
    localparam int CNT_W  = $clog2(PERIOD_CYC);
    localparam int CMP_W  = $clog2(PERIOD_CYC + 1);
    localparam int DEAD_W = $clog2(DEAD_PERIODS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);

    typedef enum logic [1:0] {
        ST_STOP    = 2'd0,
        ST_RUN_FWD = 2'd1,
        ST_RUN_BWD = 2'd2,
        ST_DEAD    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        REQ_S = 2'd0,
        REQ_F = 2'd1,
        REQ_B = 2'd2
    } req_e;

    function automatic req_e decode(input logic fwd, input logic bwd);
        if (fwd && !bwd) return REQ_F;
        if (bwd && !fwd) return REQ_B;
        return REQ_S;
    endfunction

    function automatic state_e req_state(input req_e r);
        case (r)
            REQ_F:   return ST_RUN_FWD;
            REQ_B:   return ST_RUN_BWD;
            default: return ST_STOP;
        endcase
    endfunction

    function automatic logic [CMP_W-1:0] cmp_of(input logic [1:0] code);
        return CMP_W'((int'(code) + 1) * (PERIOD_CYC / 4));
    endfunction

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sample;
    state_e            state_q [2];
    state_e            state_d [2];
    logic [DEAD_W-1:0] dead_q  [2];
    logic [DEAD_W-1:0] dead_d  [2];
    logic [1:0]        code_q  [2];
    logic [1:0]        code_d  [2];
    logic [CMP_W-1:0]  cmp_q   [2];
    logic [CMP_W-1:0]  cmp_d   [2];
    logic [1:0]        duty_w  [2];
    logic [1:0]        fwd_w, bwd_w;
    logic [1:0]        en_q, en_d;
    logic [1:0]        in1_q, in1_d;
    logic [1:0]        in2_q, in2_d;
    logic [1:0]        fault_q, fault_d;
    logic              tick_q, tick_d;

    assign fwd_w     = {FWDB, FWDA};
    assign bwd_w     = {BWDB, BWDA};
    assign duty_w[0] = DutyCycleA;
    assign duty_w[1] = DutyCycleB;

    // Everything visible on the pins is computed from next-state values, so pins change
    // on the same edge as the counter and stay glitch-free registered outputs.
    assign sample = (cnt_q == CNT_LAST);
    assign cnt_d  = sample ? '0 : cnt_q + CNT_W'(1);
    assign tick_d = (cnt_d == CNT_LAST);

    always_comb begin
        req_e req;
        req     = REQ_S;
        en_d    = '0;
        in1_d   = '0;
        in2_d   = '0;
        fault_d = fault_q;
        for (int ch = 0; ch < 2; ch++) begin
            state_d[ch] = state_q[ch];
            dead_d[ch]  = dead_q[ch];
            code_d[ch]  = code_q[ch];
            cmp_d[ch]   = cmp_q[ch];
            if (sample) begin
                req         = decode(fwd_w[ch], bwd_w[ch]);
                fault_d[ch] = fwd_w[ch] & bwd_w[ch];
                case (state_q[ch])
                    ST_STOP: state_d[ch] = req_state(req);
                    ST_RUN_FWD: begin
                        if (req == REQ_B) begin
                            state_d[ch] = ST_DEAD;
                            dead_d[ch]  = DEAD_W'(DEAD_PERIODS);
                        end else if (req == REQ_S) begin
                            state_d[ch] = ST_STOP;
                        end
                    end
                    ST_RUN_BWD: begin
                        if (req == REQ_F) begin
                            state_d[ch] = ST_DEAD;
                            dead_d[ch]  = DEAD_W'(DEAD_PERIODS);
                        end else if (req == REQ_S) begin
                            state_d[ch] = ST_STOP;
                        end
                    end
                    default: begin
                        if (dead_q[ch] == DEAD_W'(1)) state_d[ch] = req_state(req);
                        else                          dead_d[ch]  = dead_q[ch] - DEAD_W'(1);
                    end
                endcase
                if (state_d[ch] == ST_RUN_FWD || state_d[ch] == ST_RUN_BWD) begin
`ifdef MOTOR_RAMP_EN
                    if (state_d[ch] != state_q[ch])       code_d[ch] = 2'b00;
                    else if (code_q[ch] < duty_w[ch])     code_d[ch] = code_q[ch] + 2'b01;
                    else if (code_q[ch] > duty_w[ch])     code_d[ch] = code_q[ch] - 2'b01;
`else
                    code_d[ch] = duty_w[ch];
`endif
                    cmp_d[ch] = cmp_of(code_d[ch]);
                end
            end
            in1_d[ch] = (state_d[ch] == ST_RUN_FWD);
            in2_d[ch] = (state_d[ch] == ST_RUN_BWD);
            en_d[ch]  = (in1_d[ch] | in2_d[ch]) && (CMP_W'(cnt_d) < cmp_d[ch]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            en_q    <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            fault_q <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= ST_STOP;
                dead_q[ch]  <= '0;
                code_q[ch]  <= '0;
                cmp_q[ch]   <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            en_q    <= en_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            fault_q <= fault_d;
            for (int ch = 0; ch < 2; ch++) begin
                state_q[ch] <= state_d[ch];
                dead_q[ch]  <= dead_d[ch];
                code_q[ch]  <= code_d[ch];
                cmp_q[ch]   <= cmp_d[ch];
            end
        end
    end

    assign ENA           = en_q[0];
    assign ENB           = en_q[1];
    assign IN1A          = in1_q[0];
    assign IN2A          = in2_q[0];
    assign IN1B          = in1_q[1];
    assign IN2B          = in2_q[1];
    assign FaultA        = fault_q[0];
    assign FaultB        = fault_q[1];
    assign PeriodTick    = tick_q;
    assign dbg_state_a_o = state_q[0];
    assign dbg_state_b_o = state_q[1];

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: per-period scoreboard of EN/IN/Fault cycle counts against a spec model.
module tb_motor_pwm_driver;
  localparam int PC = 100;
  localparam int DP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] DutyCycleA = '0, DutyCycleB = '0;
  logic       FWDA = 0, BWDA = 0, FWDB = 0, BWDB = 0;
  logic       ENA, ENB, IN1A, IN2A, IN1B, IN2B, FaultA, FaultB, PeriodTick;
  logic [1:0] dbg_state_a_o, dbg_state_b_o;

  always #5 clk = ~clk;

  motor_pwm_driver #(.PERIOD_CYC(PC), .DEAD_PERIODS(DP)) dut (
    .clk(clk), .rst_n(rst_n),
    .DutyCycleA(DutyCycleA), .DutyCycleB(DutyCycleB),
    .FWDA(FWDA), .BWDA(BWDA), .FWDB(FWDB), .BWDB(BWDB),
    .ENA(ENA), .ENB(ENB), .IN1A(IN1A), .IN2A(IN2A), .IN1B(IN1B), .IN2B(IN2B),
    .FaultA(FaultA), .FaultB(FaultB), .PeriodTick(PeriodTick),
    .dbg_state_a_o(dbg_state_a_o), .dbg_state_b_o(dbg_state_b_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  // per channel 32 bits: {en_cycles, in1_cycles, in2_cycles, fault_cycles}; A in [63:32]
  logic [63:0] exp_q[$];

  int m_st[2];
  int m_dead[2];
  int m_code[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_st[ch] = 0;
      m_dead[ch] = 0;
      m_code[ch] = 0;
    end
  endtask

  // states: 0 STOP, 1 RUN_FWD, 2 RUN_BWD, 3 DEAD
  task automatic model_step(input int ch, input logic f, input logic b, input logic [1:0] d,
                            output logic [31:0] o);
    int req, nxt, en;
    req = (f && !b) ? 1 : ((b && !f) ? 2 : 0);
    nxt = m_st[ch];
    case (m_st[ch])
      0: nxt = req;
      1: if (req == 2) begin nxt = 3; m_dead[ch] = DP; end else if (req == 0) nxt = 0;
      2: if (req == 1) begin nxt = 3; m_dead[ch] = DP; end else if (req == 0) nxt = 0;
      default: if (m_dead[ch] == 1) nxt = req; else m_dead[ch]--;
    endcase
`ifdef MOTOR_RAMP_EN
    if (nxt != m_st[ch]) m_code[ch] = 0;
    else if (m_code[ch] < int'(d)) m_code[ch]++;
    else if (m_code[ch] > int'(d)) m_code[ch]--;
`else
    m_code[ch] = int'(d);
`endif
    m_st[ch] = nxt;
    en = (nxt == 1 || nxt == 2) ? (m_code[ch] + 1) * (PC / 4) : 0;
    o = {8'(en), 8'((nxt == 1) ? PC : 0), 8'((nxt == 2) ? PC : 0), 8'((f && b) ? PC : 0)};
  endtask

  // Called at the negedge of the cnt==0 cycle; leaves at the next period's cnt==0 negedge.
  task automatic dp(input logic fa, input logic ba, input logic [1:0] da,
                    input logic fb, input logic bb, input logic [1:0] db,
                    input bit glitch, input int rst_at);
    logic [63:0] exp;
    logic [31:0] ea, eb, ew;
    int en_c[2], in1_c[2], in2_c[2], flt_c[2], shape[2];
    int overlap, tick_err;
    logic [1:0] en_v, in1_v, in2_v, flt_v;
    string nm;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    FWDA = fa; BWDA = ba; DutyCycleA = da;
    FWDB = fb; BWDB = bb; DutyCycleB = db;
    model_step(0, fa, ba, da, ea);
    model_step(1, fb, bb, db, eb);
    exp_q.push_back({ea, eb});
    for (int ch = 0; ch < 2; ch++) begin
      en_c[ch] = 0; in1_c[ch] = 0; in2_c[ch] = 0; flt_c[ch] = 0; shape[ch] = 0;
    end
    overlap = 0;
    tick_err = 0;
    for (int i = 0; i < PC; i++) begin
      if (glitch && i == 50) begin
        FWDA = 1'($urandom_range(0, 1)); BWDA = 1'($urandom_range(0, 1));
        FWDB = 1'($urandom_range(0, 1)); BWDB = 1'($urandom_range(0, 1));
        DutyCycleA = 2'($urandom_range(0, 3)); DutyCycleB = 2'($urandom_range(0, 3));
      end
      if (glitch && i == 60) begin
        FWDA = fa; BWDA = ba; DutyCycleA = da;
        FWDB = fb; BWDB = bb; DutyCycleB = db;
      end
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_async_outs", {23'd0, ENA, ENB, IN1A, IN2A, IN1B, IN2B, FaultA, FaultB, PeriodTick}, 0);
        repeat (3) @(negedge clk);
        check("rst_hold_outs", {23'd0, ENA, ENB, IN1A, IN2A, IN1B, IN2B, FaultA, FaultB, PeriodTick}, 0);
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();
        exp_q.push_back('0);
        return;
      end
      en_v = {ENB, ENA}; in1_v = {IN1B, IN1A}; in2_v = {IN2B, IN2A}; flt_v = {FaultB, FaultA};
      for (int ch = 0; ch < 2; ch++) begin
        ew = (ch == 0) ? exp[63:32] : exp[31:0];
        en_c[ch]  += int'(en_v[ch]);
        in1_c[ch] += int'(in1_v[ch]);
        in2_c[ch] += int'(in2_v[ch]);
        flt_c[ch] += int'(flt_v[ch]);
        if (en_v[ch] !== (i < int'(ew[31:24]))) shape[ch]++;
      end
      if ((IN1A & IN2A) | (IN1B & IN2B)) overlap++;
      if (PeriodTick !== (i == PC - 1)) tick_err++;
      @(negedge clk);
    end
    for (int ch = 0; ch < 2; ch++) begin
      ew = (ch == 0) ? exp[63:32] : exp[31:0];
      nm = (ch == 0) ? "a" : "b";
      check({"en_cycles_", nm}, en_c[ch], {24'd0, ew[31:24]});
      check({"en_shape_", nm}, shape[ch], 0);
      check({"in1_cycles_", nm}, in1_c[ch], {24'd0, ew[23:16]});
      check({"in2_cycles_", nm}, in2_c[ch], {24'd0, ew[15:8]});
      check({"fault_cycles_", nm}, flt_c[ch], {24'd0, ew[7:0]});
    end
    check("in1_in2_overlap", overlap, 0);
    check("period_tick", tick_err, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outs", {23'd0, ENA, ENB, IN1A, IN2A, IN1B, IN2B, FaultA, FaultB, PeriodTick}, 0);
    check("reset_state_a", {30'd0, dbg_state_a_o}, 0);
    check("reset_state_b", {30'd0, dbg_state_b_o}, 0);
    rst_n = 1'b1;
    exp_q.push_back('0);

    // forward at 25%
    repeat (3) dp(1, 0, 2'b00, 0, 0, 2'b00, 0, -1);
    // full on, then 50%
    repeat (3) dp(1, 0, 2'b11, 0, 0, 2'b00, 0, -1);
    repeat (2) dp(1, 0, 2'b01, 0, 0, 2'b00, 1, -1);
    // reversal at 75% with dead-time
    repeat (2) dp(1, 0, 2'b10, 0, 0, 2'b00, 0, -1);
    dp(0, 1, 2'b10, 0, 0, 2'b00, 1, -1);
    repeat (3) dp(0, 1, 2'b10, 0, 0, 2'b00, 0, -1);
    // request flips back during dead-time, honoured at expiry
    dp(1, 0, 2'b10, 0, 0, 2'b00, 0, -1);
    dp(0, 1, 2'b10, 0, 0, 2'b00, 0, -1);
    repeat (2) dp(1, 0, 2'b10, 0, 0, 2'b00, 0, -1);
    // channel B fault and recovery
    dp(0, 0, 2'b00, 1, 1, 2'b01, 0, -1);
    dp(0, 0, 2'b00, 0, 0, 2'b01, 0, -1);
    dp(0, 0, 2'b00, 1, 0, 2'b11, 0, -1);
    dp(0, 0, 2'b00, 1, 1, 2'b11, 0, -1);
    repeat (4) dp(0, 0, 2'b00, 0, 1, 2'b01, 0, -1);
    // random requests with mid-period disturbances
    for (int k = 0; k < 20; k++) begin
      dp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
         1'($urandom_range(0, 1)), -1);
    end
    // reset while running at cnt=40
    repeat (2) dp(1, 0, 2'b10, 1, 0, 2'b01, 0, -1);
    dp(1, 0, 2'b10, 1, 0, 2'b01, 0, 40);
    repeat (2) dp(1, 0, 2'b10, 1, 0, 2'b01, 0, -1);
    // from STOP straight to full request
    repeat (2) dp(0, 0, 2'b00, 0, 0, 2'b00, 0, -1);
    repeat (5) dp(1, 0, 2'b11, 0, 0, 2'b00, 0, -1);
    dp(1, 0, 2'b00, 0, 0, 2'b00, 0, -1);
    repeat (3) dp(1, 0, 2'b00, 0, 0, 2'b00, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
